apb_master_mux: RTL and testbench

//  Parametrised APB master bridge: takes simple transfer requests (ptransfer/swrite/SADDR/SWDATA),

---
 rtl/apb_master_mux.sv | 203 ++++++++++++++++++++
 tb/tb_apb_master_mux.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_mux.sv
// APB master bridge: turns simple transfer requests into APB SETUP/ACCESS cycles across NUM_SLAVES PSEL lines.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_mux #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int SEL_LSB     = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic                         ptransfer,
  input  logic                         swrite,
  input  logic [ADDR_W-1:0]            SADDR,
  input  logic [DATA_W-1:0]            SWDATA,
  output logic                         s_accept,
  output logic                         s_done,
  output logic                         s_err,
  output logic [DATA_W-1:0]            f_data,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [DATA_W-1:0]            PWDATA,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [SEL_W-1:0]        req_idx;
  logic [NUM_SLAVES-1:0]   req_sel;
  logic [NUM_SLAVES-1:0]   psel_nxt;
  logic                    req_ok;
  logic                    take;
  logic                    sel_ready;
  logic                    sel_err;
  logic                    tmo_hit;
  logic                    dec_pend;
  logic                    dec_pend_nxt;
  logic                    penable_nxt;
  logic                    pwrite_nxt;
  logic                    s_done_nxt;
  logic                    s_err_nxt;
  logic [ADDR_W-1:0]       paddr_nxt;
  logic [DATA_W-1:0]       pwdata_nxt;
  logic [DATA_W-1:0]       f_data_nxt;
  logic [DATA_W-1:0]       sel_rdata;

  assign req_idx = SADDR[SEL_LSB +: SEL_W];

  // An index field value beyond NUM_SLAVES leaves req_sel empty, which flags a decode error.
  always_comb begin
    req_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      req_sel[i] = (req_idx == SEL_W'(i));
    end
  end

  assign req_ok = |req_sel;

  // The registered one-hot PSEL doubles as the response mux select.
  assign sel_ready = |(PREADY & PSEL);
  assign sel_err   = |(PSLVERR & PSEL);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (PSEL[i]) begin
        sel_rdata = sel_rdata | PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  assign s_accept = (state == IDLE) || ((state == ACCESS) && sel_ready);
  assign take     = ptransfer && s_accept;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if ((state == ACCESS) && !sel_ready) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign tmo_hit = (state == ACCESS) && !sel_ready && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

  // A bad request taken on the completing ACCESS cycle collides with that completion's s_done,
  // so its error response is deferred by one cycle through dec_pend.
  always_comb begin
    state_nxt    = state;
    psel_nxt     = PSEL;
    penable_nxt  = PENABLE;
    paddr_nxt    = PADDR;
    pwrite_nxt   = PWRITE;
    pwdata_nxt   = PWDATA;
    f_data_nxt   = f_data;
    s_done_nxt   = 1'b0;
    s_err_nxt    = 1'b0;
    dec_pend_nxt = dec_pend;

    case (state)
      IDLE: begin
        s_done_nxt   = dec_pend;
        s_err_nxt    = dec_pend;
        dec_pend_nxt = 1'b0;
        if (take && !req_ok) begin
          if (dec_pend) begin
            dec_pend_nxt = 1'b1;
          end else begin
            s_done_nxt = 1'b1;
            s_err_nxt  = 1'b1;
          end
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_nxt   = IDLE;
          psel_nxt    = '0;
          penable_nxt = 1'b0;
          s_done_nxt  = 1'b1;
          s_err_nxt   = sel_err;
          if (!PWRITE && !sel_err) begin
            f_data_nxt = sel_rdata;
          end
          if (take && !req_ok) begin
            dec_pend_nxt = 1'b1;
          end
        end else if (tmo_hit) begin
          state_nxt   = IDLE;
          psel_nxt    = '0;
          penable_nxt = 1'b0;
          s_done_nxt  = 1'b1;
          s_err_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        psel_nxt    = '0;
        penable_nxt = 1'b0;
      end
    endcase

    if (take && req_ok) begin
      state_nxt   = SETUP;
      psel_nxt    = req_sel;
      penable_nxt = 1'b0;
      paddr_nxt   = SADDR;
      pwrite_nxt  = swrite;
      pwdata_nxt  = SWDATA;
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state    <= IDLE;
      PSEL     <= '0;
      PENABLE  <= 1'b0;
      PADDR    <= '0;
      PWRITE   <= 1'b0;
      PWDATA   <= '0;
      f_data   <= '0;
      s_done   <= 1'b0;
      s_err    <= 1'b0;
      dec_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      PSEL     <= psel_nxt;
      PENABLE  <= penable_nxt;
      PADDR    <= paddr_nxt;
      PWRITE   <= pwrite_nxt;
      PWDATA   <= pwdata_nxt;
      f_data   <= f_data_nxt;
      s_done   <= s_done_nxt;
      s_err    <= s_err_nxt;
      dec_pend <= dec_pend_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master_mux.sv
// Directed testbench for apb_master_mux: a 4-slave instance for bus behaviour and a 3-slave
// instance for decode errors. Adds a timeout scenario when APB_TIMEOUT_EN is defined.
module tb_apb_master_mux;

  logic         pclk = 1'b0;
  logic         preset = 1'b0;

  always #5 pclk = ~pclk;

  logic         ptransfer, swrite;
  logic [31:0]  SADDR, SWDATA;
  logic         s_accept, s_done, s_err;
  logic [31:0]  f_data, PADDR, PWDATA;
  logic [3:0]   PSEL;
  logic         PENABLE, PWRITE;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY, PSLVERR;

  logic         b_ptransfer, b_swrite;
  logic [31:0]  b_saddr, b_swdata;
  logic         b_accept, b_done, b_err;
  logic [31:0]  b_fdata, b_paddr, b_pwdata;
  logic [2:0]   b_psel;
  logic         b_penable, b_pwrite;
  logic [95:0]  b_prdata;
  logic [2:0]   b_pready, b_pslverr;

  int testsRun = 0;
  int testsFailed = 0;

  apb_master_mux u_dut (
    .pclk(pclk), .preset(preset), .ptransfer(ptransfer), .swrite(swrite),
    .SADDR(SADDR), .SWDATA(SWDATA), .s_accept(s_accept), .s_done(s_done),
    .s_err(s_err), .f_data(f_data), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master_mux #(.NUM_SLAVES(3)) u_dut3 (
    .pclk(pclk), .preset(preset), .ptransfer(b_ptransfer), .swrite(b_swrite),
    .SADDR(b_saddr), .SWDATA(b_swdata), .s_accept(b_accept), .s_done(b_done),
    .s_err(b_err), .f_data(b_fdata), .PADDR(b_paddr), .PSEL(b_psel),
    .PENABLE(b_penable), .PWRITE(b_pwrite), .PWDATA(b_pwdata), .PRDATA(b_prdata),
    .PREADY(b_pready), .PSLVERR(b_pslverr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata);
    ptransfer = req;
    swrite    = wr;
    SADDR     = addr;
    SWDATA    = wdata;
  endtask

  // One isolated transfer starting from IDLE; the selected slave is held not-ready for 'waits' cycles.
  task automatic runXfer(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits, input logic [3:0] expSel,
                         input logic expErr);
    applyStimulus(1'b1, wr, addr, wdata);
    #1 checkOutput({tag, "_accept"}, s_accept, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput({tag, "_setup_psel"}, PSEL, expSel);
    checkOutput({tag, "_setup_penable"}, PENABLE, 0);
    checkOutput({tag, "_setup_paddr"}, PADDR, addr);
    checkOutput({tag, "_setup_pwrite"}, PWRITE, wr);
    if (wr) checkOutput({tag, "_setup_pwdata"}, PWDATA, wdata);
    if (waits > 0) PREADY = ~expSel;
    tick();
    for (int i = 0; i < waits; i++) begin
      checkOutput({tag, "_wait_penable"}, PENABLE, 1);
      checkOutput({tag, "_wait_psel"}, PSEL, expSel);
      checkOutput({tag, "_wait_accept"}, s_accept, 0);
      checkOutput({tag, "_wait_done"}, s_done, 0);
      tick();
    end
    PREADY = 4'hF;
    #1 checkOutput({tag, "_access_accept"}, s_accept, 1);
    checkOutput({tag, "_access_penable"}, PENABLE, 1);
    checkOutput({tag, "_access_paddr"}, PADDR, addr);
    tick();
    checkOutput({tag, "_done"}, s_done, 1);
    checkOutput({tag, "_err"}, s_err, expErr);
    checkOutput({tag, "_release_psel"}, PSEL, 0);
    checkOutput({tag, "_release_penable"}, PENABLE, 0);
    tick();
    checkOutput({tag, "_done_pulse"}, s_done, 0);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    PRDATA = '0;
    PREADY = 4'hF;
    PSLVERR = '0;
    b_ptransfer = 1'b0;
    b_swrite = 1'b0;
    b_saddr = '0;
    b_swdata = '0;
    b_prdata = '0;
    b_pready = 3'b111;
    b_pslverr = '0;

    repeat (3) tick();
    checkOutput("rst_psel", PSEL, 0);
    checkOutput("rst_penable", PENABLE, 0);
    checkOutput("rst_paddr", PADDR, 0);
    checkOutput("rst_pwrite", PWRITE, 0);
    checkOutput("rst_pwdata", PWDATA, 0);
    checkOutput("rst_done", s_done, 0);
    checkOutput("rst_err", s_err, 0);
    checkOutput("rst_fdata", f_data, 0);
    preset = 1'b1;
    tick();

    runXfer("wr", 1'b1, 32'h0000_0004, 32'h1234, 0, 4'b0001, 1'b0);
    checkOutput("wr_fdata", f_data, 0);

    // Slave 0 raises PSLVERR and slave 1 is selected; the unselected error must be ignored.
    PRDATA[0*32 +: 32] = 32'h1111;
    PRDATA[1*32 +: 32] = 32'hCAFE;
    PSLVERR = 4'b0001;
    runXfer("rd", 1'b0, 32'h0000_1008, 32'h0, 3, 4'b0010, 1'b0);
    checkOutput("rd_fdata", f_data, 32'hCAFE);
    PSLVERR = '0;

    PRDATA[2*32 +: 32] = 32'h5A5A;
    applyStimulus(1'b1, 1'b1, 32'h0000_000A, 32'h77);
    #1 checkOutput("b2b_accept1", s_accept, 1);
    tick();
    checkOutput("b2b_setup1_psel", PSEL, 4'b0001);
    applyStimulus(1'b1, 1'b0, 32'h0000_2003, 32'h0);
    #1 checkOutput("b2b_setup_accept", s_accept, 0);
    tick();
    checkOutput("b2b_access1_psel", PSEL, 4'b0001);
    checkOutput("b2b_access1_penable", PENABLE, 1);
    checkOutput("b2b_access1_pwdata", PWDATA, 32'h77);
    checkOutput("b2b_accept2", s_accept, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("b2b_setup2_psel", PSEL, 4'b0100);
    checkOutput("b2b_setup2_penable", PENABLE, 0);
    checkOutput("b2b_setup2_paddr", PADDR, 32'h0000_2003);
    checkOutput("b2b_setup2_pwrite", PWRITE, 0);
    checkOutput("b2b_done1", s_done, 1);
    checkOutput("b2b_err1", s_err, 0);
    tick();
    checkOutput("b2b_access2_psel", PSEL, 4'b0100);
    checkOutput("b2b_access2_penable", PENABLE, 1);
    checkOutput("b2b_gap_done", s_done, 0);
    tick();
    checkOutput("b2b_done2", s_done, 1);
    checkOutput("b2b_fdata", f_data, 32'h5A5A);
    checkOutput("b2b_release_psel", PSEL, 0);
    tick();

    PSLVERR = 4'b0100;
    runXfer("werr", 1'b1, 32'h0000_2010, 32'hBEEF, 0, 4'b0100, 1'b1);
    checkOutput("werr_fdata", f_data, 32'h5A5A);

    PRDATA[3*32 +: 32] = 32'hDEAD;
    PSLVERR = 4'b1000;
    runXfer("rderr", 1'b0, 32'h0000_3000, 32'h0, 1, 4'b1000, 1'b1);
    checkOutput("rderr_fdata", f_data, 32'h5A5A);
    PSLVERR = '0;

    b_ptransfer = 1'b1;
    b_saddr = 32'h0000_3000;
    #1 checkOutput("dec_accept", b_accept, 1);
    tick();
    b_ptransfer = 1'b0;
    checkOutput("dec_psel", b_psel, 0);
    checkOutput("dec_penable", b_penable, 0);
    checkOutput("dec_done", b_done, 1);
    checkOutput("dec_err", b_err, 1);
    tick();
    checkOutput("dec_done_pulse", b_done, 0);
    checkOutput("dec_fdata", b_fdata, 0);

`ifdef APB_TIMEOUT_EN
    PREADY = 4'b1101;
    applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 15; i++) begin
      checkOutput("tmo_wait_penable", PENABLE, 1);
      checkOutput("tmo_wait_done", s_done, 0);
      tick();
    end
    tick();
    checkOutput("tmo_done", s_done, 1);
    checkOutput("tmo_err", s_err, 1);
    checkOutput("tmo_psel", PSEL, 0);
    checkOutput("tmo_penable", PENABLE, 0);
    checkOutput("tmo_fdata", f_data, 32'h5A5A);
    PREADY = 4'hF;
    tick();
`endif

    PREADY = 4'b1101;
    applyStimulus(1'b1, 1'b0, 32'h0000_1004, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("mid_penable_before", PENABLE, 1);
    #2 preset = 1'b0;
    #1 checkOutput("mid_rst_psel", PSEL, 0);
    checkOutput("mid_rst_penable", PENABLE, 0);
    checkOutput("mid_rst_done", s_done, 0);
    checkOutput("mid_rst_fdata", f_data, 0);
    tick();
    preset = 1'b1;
    PREADY = 4'hF;
    tick();
    checkOutput("post_rst_done", s_done, 0);
    checkOutput("post_rst_psel", PSEL, 0);
    tick();
    checkOutput("post_rst_done2", s_done, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
